// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and framing constants.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    localparam int UART_DATA_BITS   = 8;
    localparam int UART_MIN_DIV     = 2;
    localparam int UART_DEFAULT_DIV = 106;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers for full/empty detection.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) &&
                       (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_level   = r_wptr - r_rptr;
    assign o_rdata   = r_mem[r_rptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter with runtime bit-period divider.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DIV_W = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [DIV_W-1:0]       cfg_div,
    input  logic                   wr_valid,
    input  logic [7:0]             wr_data,
    output logic                   wr_ready,
    output logic                   tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_level
);

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic [7:0]       w_head;
    logic [DIV_W-1:0] w_div_in;
    logic             w_bit_end;
    logic             w_last_bit;

    tx_state_t        r_state;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_baud;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_tx;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (wr_valid),
        .i_wdata (wr_data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign w_div_in   = (cfg_div < DIV_W'(UART_MIN_DIV)) ?
                        DIV_W'(UART_MIN_DIV) : cfg_div;
    assign w_bit_end  = (r_baud == r_div - DIV_W'(1));
    assign w_last_bit = (r_bit == 3'(UART_DATA_BITS - 1));
    // A new frame starts from IDLE or straight out of a finished stop bit.
    assign w_pop      = !w_empty &&
                        ((r_state == ST_IDLE) ||
                         (r_state == ST_STOP && w_bit_end));

    assign wr_ready = !w_full;
    assign tx       = r_tx;
    assign busy     = (r_state != ST_IDLE) || !w_empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_div   <= DIV_W'(UART_MIN_DIV);
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else if (w_pop) begin
            r_state <= ST_START;
            r_shift <= w_head;
            r_div   <= w_div_in;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (w_last_bit) begin
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                            r_tx  <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame capture, timing and FIFO corners.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] cfg_div = 16'd106;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_ready;
    logic        tx;
    logic        busy;
    logic [4:0]  fifo_level;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_fifo #(
        .DEPTH (16),
        .DIV_W (16)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cfg_div    (cfg_div),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] div;
        logic [7:0]  data;
        int          per;
        int          busy_cyc;
    } vec_t;

    vec_t vecs[7];

    logic [7:0] r_d;
    logic [7:0] r_d2;
    int g_gap, g_bad, g_nb, g_busy;
    int g_gap2, g_bad2, g_nb2;
    int first_k, lvl_at_full, gap_sum, bad_sum, nb_sum, idle_bad;
    logic [7:0] got [20];

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [7:0] b);
        int t = 0;
        wr_valid = 1'b1;
        wr_data  = b;
        while (wr_ready !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (wr_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: wr_ready=%b required 1", wr_ready);
        end
        @(negedge clk);
    endtask

    // Captures one frame sampled at negedges, bit period per.
    task automatic rx_frame(input int per, output logic [7:0] d,
                            output int gap, output int bad,
                            output int nb);
        logic seg;
        gap = 0;
        bad = 0;
        nb  = 0;
        d   = 8'h00;
        seg = 1'b0;
        while (tx !== 1'b0 && gap < 5000) begin
            @(negedge clk);
            gap++;
        end
        if (tx !== 1'b0) begin
            bad = 1000;
            return;
        end
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < per; j++) begin
                if (j == 0) begin
                    seg = tx;
                    if (k >= 1 && k <= 8) d[k-1] = tx;
                    if (k == 9 && tx !== 1'b1) bad++;
                end
                if (tx !== seg) bad++;
                if (busy !== 1'b1) nb++;
                @(negedge clk);
            end
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 20000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        vecs[0] = '{16'd106, 8'h41, 106, 1061};
        vecs[1] = '{16'd0,   8'hA5, 2,   21};
        vecs[2] = '{16'd1,   8'h3C, 2,   21};
        vecs[3] = '{16'd2,   8'h80, 2,   21};
        vecs[4] = '{16'd3,   8'h01, 3,   31};
        vecs[5] = '{16'd5,   8'hFF, 5,   51};
        vecs[6] = '{16'd7,   8'h00, 7,   71};

        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_level", 32'(fifo_level), 32'd0);
        resetn = 1'b1;

        idle_bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b1 ||
                fifo_level !== 5'd0) idle_bad++;
        end
        check("idle_100", 32'(idle_bad), 32'd0);

        for (int i = 0; i < 7; i++) begin
            cfg_div = vecs[i].div;
            push(vecs[i].data);
            wr_valid = 1'b0;
            check($sformatf("v%0d_level", i), 32'(fifo_level), 32'd1);
            fork
                rx_frame(vecs[i].per, r_d, g_gap, g_bad, g_nb);
                count_busy(g_busy);
            join
            check($sformatf("v%0d_data", i), 32'(r_d), 32'(vecs[i].data));
            check($sformatf("v%0d_timing", i), 32'(g_bad), 32'd0);
            check($sformatf("v%0d_latency", i), 32'(g_gap), 32'd1);
            check($sformatf("v%0d_busy_cyc", i), 32'(g_busy),
                  32'(vecs[i].busy_cyc));
            @(negedge clk);
        end

        cfg_div = 16'd106;
        fork
            begin
                push(8'h48);
                push(8'h69);
                push(8'h0A);
                wr_valid = 1'b0;
            end
            begin
                rx_frame(106, r_d, g_gap, g_bad, g_nb);
                check("b2b_h", 32'(r_d), 32'h48);
                check("b2b_h_ok", 32'(g_bad + g_nb), 32'd0);
                rx_frame(106, r_d, g_gap, g_bad, g_nb);
                check("b2b_i", 32'(r_d), 32'h69);
                check("b2b_i_gap", 32'(g_gap), 32'd0);
                check("b2b_i_ok", 32'(g_bad + g_nb), 32'd0);
                rx_frame(106, r_d, g_gap, g_bad, g_nb);
                check("b2b_nl", 32'(r_d), 32'h0A);
                check("b2b_nl_gap", 32'(g_gap), 32'd0);
                check("b2b_nl_ok", 32'(g_bad + g_nb), 32'd0);
                check("b2b_busy_low", 32'(busy), 32'd0);
            end
        join

        @(negedge clk);
        cfg_div = 16'd4;
        first_k = 0;
        lvl_at_full = 0;
        gap_sum = 0;
        bad_sum = 0;
        nb_sum = 0;
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    push(8'(8'h10 + k * 7));
                    if (wr_ready === 1'b0 && first_k == 0) begin
                        first_k = k + 1;
                        lvl_at_full = int'(fifo_level);
                    end
                end
                wr_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 20; k++) begin
                    rx_frame(4, got[k], g_gap2, g_bad2, g_nb2);
                    if (k > 0) gap_sum += g_gap2;
                    bad_sum += g_bad2;
                    nb_sum += g_nb2;
                end
            end
        join
        check("full_after_accept", 32'(first_k), 32'd17);
        check("full_level", 32'(lvl_at_full), 32'd16);
        for (int k = 0; k < 20; k++)
            check($sformatf("burst_b%0d", k), 32'(got[k]),
                  32'(8'(8'h10 + k * 7)));
        check("burst_gaps", 32'(gap_sum), 32'd0);
        check("burst_timing", 32'(bad_sum + nb_sum), 32'd0);
        check("burst_empty", 32'(fifo_level), 32'd0);

        @(negedge clk);
        cfg_div = 16'd8;
        push(8'h3C);
        push(8'hC3);
        wr_valid = 1'b0;
        fork
            begin
                repeat (5) @(negedge clk);
                cfg_div = 16'd20;
            end
            begin
                rx_frame(8, r_d, g_gap, g_bad, g_nb);
                rx_frame(20, r_d2, g_gap2, g_bad2, g_nb2);
            end
        join
        check("cfg_f1_data", 32'(r_d), 32'h3C);
        check("cfg_f1_timing", 32'(g_bad), 32'd0);
        check("cfg_f2_data", 32'(r_d2), 32'hC3);
        check("cfg_f2_timing", 32'(g_bad2), 32'd0);
        check("cfg_f2_gap", 32'(g_gap2), 32'd0);

        @(negedge clk);
        cfg_div = 16'd8;
        push(8'h00);
        push(8'hFF);
        push(8'h11);
        wr_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("pre_rst_tx", 32'(tx), 32'd0);
        check("pre_rst_level", 32'(fifo_level), 32'd2);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_tx", 32'(tx), 32'd1);
        check("async_rst_level", 32'(fifo_level), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_tx", 32'(tx), 32'd1);
        push(8'h55);
        wr_valid = 1'b0;
        fork
            rx_frame(8, r_d, g_gap, g_bad, g_nb);
            count_busy(g_busy);
        join
        check("post_rst_data", 32'(r_d), 32'h55);
        check("post_rst_timing", 32'(g_bad + g_nb), 32'd0);
        check("post_rst_busy", 32'(g_busy), 32'd81);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter that drives the SoC serial output line (`ser_tx`) consumed by the bench's serial monitor. CPU-side writes are queued in a small synchronous FIFO and serialised LSB-first with a runtime-programmable bit period. At the default divider one bit lasts 106 clocks, which matches the monitor's 53-cycle half period.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `DIV_W`, 16: width of the bit-period divider.

Ports:
- `clk`  in  1: single system clock.
- `resetn`  in  1: asynchronous, active-low reset.
- `cfg_div`  in  DIV_W: clocks per bit. Values below 2 are treated as 2. Sampled at each frame start.
- `wr_valid`  in  1: write request.
- `wr_data`  in  8: byte to send.
- `wr_ready`  out  1: FIFO not full. Equals `!full`, with no same-cycle pop look-ahead.
- `tx`  out  1: serial line, idle high.
- `busy`  out  1: frame in progress or FIFO non-empty.
- `fifo_level`  out  $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Push occurs when `wr_valid && wr_ready` is true at a rising edge. If `wr_valid` is high while full, the write is not accepted and no data is lost or overwritten; the writer holds.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when the FIFO is non-empty. On this edge the FSM pops the head into the shift register, latches `max(cfg_div,2)` into `div_q`, and clears the bit counter and baud counter.
  - START: `tx`=0 for `div_q` cycles, then → DATA.
  - DATA: `tx`=shift[0] for `div_q` cycles per bit, then shift right. After 8 bits → STOP.
  - STOP: `tx`=1 for `div_q` cycles. Then → START if the FIFO is non-empty (pop on the same edge), otherwise → IDLE.
- The baud counter runs 0..`div_q`−1 and wraps. A bit ends on the cycle the counter equals `div_q`−1.
- The bit counter is 3 bits and counts 0..7.
- Changing `cfg_div` mid-frame has no effect until the next frame start.
- Simultaneous push and pop: both occur and `fifo_level` is unchanged. Push-on-full is rejected even when a pop happens on the same edge.
- FIFO pointers are `$clog2(DEPTH)`+1 bits; full/empty are decided by MSB comparison.
- Reset mid-frame: the frame is abandoned, `tx` returns to 1 immediately (asynchronously), the FIFO is emptied, and the FSM goes to IDLE.

## Timing
- Reset values: `tx`=1, `busy`=0, `wr_ready`=1, `fifo_level`=0, state IDLE.
- All outputs are registered or derived from registers only. `tx` comes from a flop with no combinational path from inputs.
- Latency: write accepted at edge N while idle and empty → `fifo_level`=1 after N. Pop and START at edge N+1, so `tx` falls after edge N+1.
- Frame length is exactly 10·`div_q` cycles.
- Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
- `busy` falls on the same edge the FSM enters IDLE with the FIFO empty.
- `wr_ready` rises the cycle after a pop frees a full FIFO.

## Structure
- Package `uart_pkg` holds:
  - state enum `tx_state_t` (IDLE/START/DATA/STOP);
  - `UART_DATA_BITS`=8;
  - `UART_MIN_DIV`=2;
  - `UART_DEFAULT_DIV`=106.
- Sub-module `sync_fifo` is parameterised by width and depth. It has push/pop, full/empty and level, plus async active-low reset, and is reused later by the RX path.
- The top level contains the FSM, baud counter, bit counter and shift register. Expected size is about 200 lines total.

## Test plan
- Reset, then idle 100 cycles → `tx`=1, `busy`=0, `wr_ready`=1, `fifo_level`=0 throughout.
- `cfg_div`=106, write 0x41 → `tx` low for 106 cycles, then bits 1,0,0,0,0,0,1,0 of 106 cycles each, then high for 106 cycles. Monitor prints 'A'. `busy` is high for 1061 cycles from the write.
- Write 0x48, 0x69, 0x0A on consecutive cycles → three frames with no gap (3180 cycles from first `tx` fall to `busy` low). Monitor prints 'H', 'i', then "Serial data: 10".
- `cfg_div`=4, hold `wr_valid` and write 20 bytes → `wr_ready` low after 16 entries are stored (first byte already popped, so level reaches 16 on the 17th accept). Stalled writes resume as frames drain, and all 20 bytes appear in order.
- `cfg_div`=0 and 1 → bit period is 2 cycles. Changing `cfg_div` from 8 to 20 mid-frame → the current frame stays at 8, and the next frame uses 20.
- Assert `resetn` low in the middle of DATA → `tx`=1 immediately, FIFO level 0. After release, a new write of 0x55 produces a clean frame.
